// File: rtl/acc_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : acc_alu_seq
//  Purpose  : Accumulator ALU with iterative shift-add fixed-point multiply
//             and Zero/Neg/Ovf status. Define ACC_ALU_SAT_EN for saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_alu_seq #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] RegData,
  input  logic [WIDTH-1:0] SW,
  input  logic [2:0]       Func,
  input  logic             WE,
  input  logic             SelSW,
  input  logic             SelImm,
  output logic [WIDTH-1:0] Out,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf
);

  localparam logic [2:0] c_OP_ADD  = 3'd0;
  localparam logic [2:0] c_OP_ADDI = 3'd1;
  localparam logic [2:0] c_OP_SUB  = 3'd2;
  localparam logic [2:0] c_OP_SUBI = 3'd3;
  localparam logic [2:0] c_OP_MULI = 3'd4;
  localparam logic [2:0] c_OP_MULR = 3'd5;
  localparam logic [2:0] c_OP_RTA  = 3'd6;
  localparam logic [2:0] c_OP_LSW  = 3'd7;

`ifdef ACC_ALU_SAT_EN
  localparam bit c_SAT_EN = 1'b1;
`else
  localparam bit c_SAT_EN = 1'b0;
`endif

  localparam int                c_CW   = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);
  localparam logic [WIDTH-1:0]  c_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_acc;
  logic                  r_ovf;
  logic                  r_done;
  logic                  r_neg;
  logic [c_CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]    r_prod;
  logic [2*WIDTH-1:0]    r_mcand;
  logic [WIDTH:0]        r_mplier;

  logic [WIDTH-1:0]      w_opa;
  logic [WIDTH:0]        w_acc_x;
  logic [WIDTH:0]        w_opa_x;
  logic                  w_is_sub;
  logic                  w_is_mul;
  logic [WIDTH:0]        w_sum;
  logic                  w_arith_ovf;
  logic [WIDTH-1:0]      w_arith_res;
  logic [WIDTH-1:0]      w_mplier_src;
  logic [WIDTH:0]        w_mplier_x;
  logic [WIDTH:0]        w_mcand_mag;
  logic [WIDTH:0]        w_mplier_mag;
  logic [2*WIDTH-1:0]    w_prod_s;
  logic signed [2*WIDTH-1:0] w_shift;
  logic [WIDTH:0]        w_hi;
  logic                  w_mul_ovf;
  logic [WIDTH-1:0]      w_mul_res;

  assign w_opa    = SelSW ? SW : (SelImm ? Imm : RegData);
  assign w_is_sub = (Func == c_OP_SUB) || (Func == c_OP_SUBI);
  assign w_is_mul = (Func == c_OP_MULI) || (Func == c_OP_MULR);

  // One extra bit of headroom exposes signed overflow as sum[W] != sum[W-1]
  assign w_acc_x     = {r_acc[WIDTH-1], r_acc};
  assign w_opa_x     = {w_opa[WIDTH-1], w_opa};
  assign w_sum       = w_is_sub ? (w_acc_x - w_opa_x) : (w_acc_x + w_opa_x);
  assign w_arith_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
  assign w_arith_res = (c_SAT_EN && w_arith_ovf) ? (w_sum[WIDTH] ? c_MIN : c_MAX)
                                                 : w_sum[WIDTH-1:0];

  // Magnitudes carry WIDTH+1 bits so -2^(WIDTH-1) stays exact
  assign w_mplier_src = (Func == c_OP_MULI) ? Imm : w_opa;
  assign w_mplier_x   = {w_mplier_src[WIDTH-1], w_mplier_src};
  assign w_mcand_mag  = r_acc[WIDTH-1] ? -w_acc_x : w_acc_x;
  assign w_mplier_mag = w_mplier_src[WIDTH-1] ? -w_mplier_x : w_mplier_x;

  assign w_prod_s  = r_neg ? -r_prod : r_prod;
  assign w_shift   = $signed(w_prod_s) >>> FRAC_BITS;
  assign w_hi      = w_shift[2*WIDTH-1:WIDTH-1];
  assign w_mul_ovf = ~((&w_hi) | ~(|w_hi));
  assign w_mul_res = (c_SAT_EN && w_mul_ovf) ? (r_neg ? c_MIN : c_MAX)
                                             : w_shift[WIDTH-1:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (WE && w_is_mul) w_state_next = S_MUL;
      S_MUL:   if (r_cnt == c_LAST) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (WE) begin
            case (Func)
              c_OP_ADD, c_OP_ADDI, c_OP_SUB, c_OP_SUBI: begin
                r_acc <= w_arith_res;
                r_ovf <= w_arith_ovf;
              end
              c_OP_RTA, c_OP_LSW: begin
                r_acc <= w_opa;
                r_ovf <= 1'b0;
              end
              c_OP_MULI, c_OP_MULR: begin
                r_mcand  <= {{(WIDTH-1){1'b0}}, w_mcand_mag};
                r_mplier <= w_mplier_mag;
                r_neg    <= r_acc[WIDTH-1] ^ w_mplier_src[WIDTH-1];
                r_prod   <= '0;
                r_cnt    <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_ONE;
        end
        S_FIN: begin
          r_acc <= w_mul_res;
          r_ovf <= w_mul_ovf;
        end
        default: ;
      endcase
    end
  end

  assign Out  = r_acc;
  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign Ovf  = r_ovf;
  assign Zero = (r_acc == '0);
  assign Neg  = r_acc[WIDTH-1];

endmodule
`default_nettype wire
